// File: rtl/day_of_year_decoder_pkg.sv
// Shared calendar constants and the decoder state encoding.
package day_of_year_decoder_pkg;

  localparam logic [3:0] MONTH_JAN = 4'd1;
  localparam logic [3:0] MONTH_FEB = 4'd2;
  localparam logic [3:0] MONTH_MAR = 4'd3;
  localparam logic [3:0] MONTH_APR = 4'd4;
  localparam logic [3:0] MONTH_MAY = 4'd5;
  localparam logic [3:0] MONTH_JUN = 4'd6;
  localparam logic [3:0] MONTH_JUL = 4'd7;
  localparam logic [3:0] MONTH_AUG = 4'd8;
  localparam logic [3:0] MONTH_SEP = 4'd9;
  localparam logic [3:0] MONTH_OCT = 4'd10;
  localparam logic [3:0] MONTH_NOV = 4'd11;
  localparam logic [3:0] MONTH_DEC = 4'd12;

  localparam logic [8:0] DAYS_NORMAL = 9'd365;
  localparam logic [8:0] DAYS_LEAP   = 9'd366;
  localparam int unsigned YEAR_MAX   = 99;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/day_of_year_decoder_if.sv
// Request/result bundle between the scheduler side (master) and the decoder (slave).
interface day_of_year_decoder_if;

  logic       start;
  logic [6:0] year;
  logic [8:0] yday;
  logic       ready;
  logic       busy;
  logic       done;
  logic       error;
  logic [6:0] month;
  logic [4:0] day;

  modport master (
    output start, year, yday,
    input  ready, busy, done, error, month, day
  );

  modport slave (
    input  start, year, yday,
    output ready, busy, done, error, month, day
  );

endinterface

// File: rtl/day_of_year_decoder_month_length_lut.sv
// Days in month m (1..12) for a normal or leap year; 0 for any other m.
module day_of_year_decoder_month_length_lut
  import day_of_year_decoder_pkg::*;
(
  input  logic [3:0] m,
  input  logic       leap,
  output logic [4:0] len
);

  // Pure table lookup of month length.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    len = 5'd0;
    case (m)
      MONTH_JAN, MONTH_MAR, MONTH_MAY, MONTH_JUL,
      MONTH_AUG, MONTH_OCT, MONTH_DEC:            len = 5'd31;
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: len = 5'd30;
      MONTH_FEB:                                  len = leap ? 5'd29 : 5'd28;
      default:                                    len = 5'd0;
    endcase
  end

endmodule

// File: rtl/day_of_year_decoder.sv
// Iterative day-of-year to month/day decoder: subtracts one month length per
// cycle until the remainder fits in the current month.
module day_of_year_decoder #(
  parameter int unsigned YEAR_MAX = day_of_year_decoder_pkg::YEAR_MAX
) (
  input logic                   clk,
  input logic                   rst,
  day_of_year_decoder_if.slave  bus
);

  import day_of_year_decoder_pkg::*;

  state_t     state_q, state_d;
  logic [8:0] rem_q, rem_d;
  logic [3:0] m_q, m_d;
  logic       leap_q, leap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [6:0] month_q, month_d;
  logic [4:0] day_q, day_d;

  logic [4:0] len;
  logic       start_leap;
  logic [8:0] yday_limit;
  logic       start_bad;

  // Leap is latched at start, so the table only ever sees a registered bit.
  day_of_year_decoder_month_length_lut u_month_length_lut (
    .m    (m_q),
    .leap (leap_q),
    .len  (len)
  );

  assign start_leap = (bus.year[1:0] == 2'b00);
  assign yday_limit = start_leap ? DAYS_LEAP : DAYS_NORMAL;
  assign start_bad  = ({25'd0, bus.year} > YEAR_MAX) ||
                      (bus.yday == 9'd0) ||
                      (bus.yday > yday_limit);

  // Next-state and datapath update: accept/validate in IDLE, peel months in RUN.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    m_d     = m_q;
    leap_d  = leap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    month_d = month_q;
    day_d   = day_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          leap_d  = start_leap;
          error_d = 1'b0;
          if (start_bad) begin
            error_d = 1'b1;
            month_d = 7'd0;
            day_d   = 5'd0;
            done_d  = 1'b1;
          end else begin
            rem_d   = bus.yday;
            m_d     = MONTH_JAN;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (rem_q <= {4'd0, len}) begin
          month_d = {3'd0, m_q};
          day_d   = rem_q[4:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (m_q >= MONTH_DEC) begin
          // Unreachable after input validation; bail out rather than run past December.
          error_d = 1'b1;
          month_d = 7'd0;
          day_d   = 5'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rem_d = rem_q - {4'd0, len};
          m_d   = m_q + 4'd1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any decode in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 9'd0;
      m_q     <= 4'd0;
      leap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      month_q <= 7'd0;
      day_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      m_q     <= m_d;
      leap_q  <= leap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      month_q <= month_d;
      day_q   <= day_d;
    end
  end

  assign bus.ready = ~busy_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;
  assign bus.month = month_q;
  assign bus.day   = day_q;

endmodule

// File: tb/tb_day_of_year_decoder.sv
// Self-checking bench for day_of_year_decoder: directed cases plus a full
// sweep and random requests, scored against a calendar-arithmetic model.
module tb_day_of_year_decoder;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  day_of_year_decoder_if bus ();

  day_of_year_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Calendar reference: walk a month-length table; latency equals the month number.
  function automatic void model(input int y, input int yd,
                                output int em, output int ed, output int eerr);
    int lens[12];
    int r;
    bit lp;
    lens = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    lp   = (y % 4 == 0);
    if (lp) lens[1] = 29;
    em = 0; ed = 0; eerr = 0;
    if (y > 99 || yd < 1 || yd > (lp ? 366 : 365)) begin
      eerr = 1;
      return;
    end
    r = yd;
    for (int i = 0; i < 12; i++) begin
      if (r <= lens[i]) begin
        em = i + 1;
        ed = r;
        return;
      end
      r -= lens[i];
    end
  endfunction

  // Present a request for one edge; returns half a cycle after the start edge.
  task automatic launch(input int y, input int yd);
    @(negedge clk);
    bus.year  = 7'(y);
    bus.yday  = 9'(yd);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count cycles past the start edge until done is seen (bounded).
  task automatic wait_done(input string tag, output int lat, output bit saw_busy);
    lat = 0;
    saw_busy = 1'b0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) saw_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check({tag, ".done_timeout"}, 32'(bus.done), 32'd1);
  endtask

  // Compare the result in the done cycle against the model.
  task automatic score(input string tag, input int y, input int yd, input int lat, input bit saw_busy);
    int em, ed, eerr;
    model(y, yd, em, ed, eerr);
    check({tag, ".latency"}, 32'(lat), eerr ? 32'd0 : 32'(em));
    check({tag, ".month"},   32'(bus.month), 32'(em));
    check({tag, ".day"},     32'(bus.day),   32'(ed));
    check({tag, ".error"},   32'(bus.error), 32'(eerr));
    check({tag, ".ready"},   32'(bus.ready), 32'd1);
    if (eerr != 0) check({tag, ".busy_seen"}, 32'(saw_busy), 32'd0);
  endtask

  task automatic decode(input string tag, input int y, input int yd);
    int lat;
    bit sb;
    launch(y, yd);
    wait_done(tag, lat, sb);
    score(tag, y, yd, lat, sb);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat, lat2, done_cnt;
    bit sb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.year  = '0;
    bus.yday  = '0;
    repeat (3) @(negedge clk);
    check("reset.busy",  32'(bus.busy),  32'd0);
    check("reset.done",  32'(bus.done),  32'd0);
    check("reset.error", 32'(bus.error), 32'd0);
    check("reset.month", 32'(bus.month), 32'd0);
    check("reset.day",   32'(bus.day),   32'd0);
    check("reset.ready", 32'(bus.ready), 32'd1);
    rst = 1'b0;

    // Leap boundary and year extremes.
    decode("leap_feb29", 24, 60);
    decode("nonleap_mar1", 23, 60);
    decode("y0_dec31", 0, 366);
    decode("y99_jan1", 99, 1);

    // Invalid requests.
    decode("err_366_nonleap", 23, 366);
    decode("err_yday0", 50, 0);
    decode("err_year100", 100, 10);

    // Reset in the middle of a decode.
    launch(23, 300);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset.busy",  32'(bus.busy),  32'd0);
    check("midreset.ready", 32'(bus.ready), 32'd1);
    check("midreset.month", 32'(bus.month), 32'd0);
    check("midreset.day",   32'(bus.day),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("midreset.no_done", 32'(done_cnt), 32'd0);

    // Start while busy is ignored.
    launch(23, 200);
    repeat (2) @(negedge clk);
    bus.year  = 7'd24;
    bus.yday  = 9'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_ignore", lat, sb);
    score("busy_ignore", 23, 200, lat + 3, sb);
    @(negedge clk);
    check("busy_ignore.done_pulse", 32'(bus.done), 32'd0);

    // Start accepted in the done cycle.
    launch(23, 31);
    wait_done("b2b_first", lat, sb);
    score("b2b_first", 23, 31, lat, sb);
    bus.year  = 7'd24;
    bus.yday  = 9'd32;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b2b_second", lat2, sb);
    score("b2b_second", 24, 32, lat2, sb);
    @(negedge clk);
    check("b2b_second.done_pulse", 32'(bus.done), 32'd0);

    // Every day of a normal and a leap year.
    for (int d = 1; d <= 365; d++) decode("sweep23", 23, d);
    for (int d = 1; d <= 366; d++) decode("sweep24", 24, d);

    // Random requests, including out-of-range years and days.
    for (int i = 0; i < 60; i++) begin
      int y, yd;
      y  = int'($urandom_range(0, 110));
      yd = int'($urandom_range(0, 370));
      decode("random", y, yd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
